turtle_mem_dump: RTL and testbench
==================================

Name: turtle_mem_dump

Overview:
Hardware readout engine that serialises the CPU's final architectural state onto a byte stream for a UART transmitter or debug link. On a start pulse, e.g. a halt or button, it reads every data-memory location and every register-file entry through synchronous read ports. It emits them framed by a header byte and an optional trailing checksum. It sits in turtle_cpu_subsystem beside data_memory and the register file, on their debug read ports, so hardware reaches the same final-state visibility as the simulation dump.

Parameters:
DMEM_ADDR_WIDTH, 8, data-memory address width; 2**DMEM_ADDR_WIDTH bytes dumped
RF_DEPTH, 16, register-file entries dumped, indices 0..RF_DEPTH-1
RF_ADDR_WIDTH, $clog2(RF_DEPTH), register-file address width
HEADER_BYTE, 8'hA5, first byte of every frame

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
start  input  1  begin dump; sampled only in IDLE
dmem_rd_en  output  1  data-memory read strobe
dmem_rd_addr  output  DMEM_ADDR_WIDTH  data-memory read address
dmem_rd_data  input  8  data-memory read data, valid one cycle after dmem_rd_en
rf_rd_en  output  1  register-file read strobe
rf_rd_addr  output  RF_ADDR_WIDTH  register-file read address
rf_rd_data  input  8  register-file read data, valid one cycle after rf_rd_en
tx_data  output  8  stream byte
tx_valid  output  1  stream byte valid
tx_ready  input  1  sink accepts byte when tx_valid && tx_ready at a rising edge
busy  output  1  frame in progress
done  output  1  one-cycle pulse after the final byte is accepted

Behaviour:
- One clock; reset is asynchronous, active-high.
- Reset values: tx_data=0, tx_valid=0, dmem_rd_en=0, dmem_rd_addr=0, rf_rd_en=0, rf_rd_addr=0, busy=0, done=0; FSM=IDLE; checksum=0.
- Frame order: HEADER_BYTE, dmem[0..2**DMEM_ADDR_WIDTH-1], rf[0..RF_DEPTH-1], then checksum if the optional feature is compiled in.
- FSM states: IDLE, SEND_HDR, RD_REQ, RD_WAIT, SEND_BYTE, SEND_SUM, FINISH.
- IDLE: on start=1, go to SEND_HDR. Register tx_data=HEADER_BYTE and tx_valid=1, set busy=1, clear checksum, clear index, select the DMEM region.
- SEND_HDR, SEND_BYTE, SEND_SUM: hold tx_valid and tx_data stable until tx_ready; unbounded stall allowed. On acceptance, drop tx_valid and add the byte to checksum modulo 256. Then go to RD_REQ, FINISH, or the next region as appropriate.
- RD_REQ (one cycle): assert the selected region's rd_en with rd_addr=index; the other region's rd_en stays 0.
- RD_WAIT (one cycle): capture rd_data into tx_data, set tx_valid=1, go to SEND_BYTE.
- Index counter is one bit wider than the region address, so end-of-region is detected without wrap aliasing.
  - At DMEM end: switch to the RF region with index=0.
  - At RF end: go to SEND_SUM (checksum builds) or FINISH.
- FINISH: done=1 and busy=0 for exactly one cycle, then IDLE.
- Throughput with tx_ready tied high: one byte per 3 cycles for memory bytes; header and checksum take 1 cycle each.
- start is ignored while busy=1 and in FINISH; no queuing.
- Reset mid-frame: immediate return to IDLE with the reset values above; the partial frame is abandoned and no done pulse is issued.
- tx_valid never deasserts without acceptance, and tx_data never changes while tx_valid=1 and tx_ready=0.

Optional Feature:
TURTLE_MEM_DUMP_CHECKSUM_EN
- Defined: after the last RF byte, emit one checksum byte: 8-bit sum mod 256 of all preceding frame bytes, header included. Frame length = 2 + 2**DMEM_ADDR_WIDTH + RF_DEPTH.
- Undefined: no SEND_SUM state, no checksum register. Frame length = 1 + 2**DMEM_ADDR_WIDTH + RF_DEPTH; RF end goes directly to FINISH.

Decomposition:
- Shared turtle CPU package: dump_state_t enum (the seven states), DUMP_HEADER_BYTE constant (8'hA5), dump_region_t enum (REGION_DMEM, REGION_RF).
- FSM, index counter and checksum accumulator stay inline.
- One natural sub-module: turtle_mem_dump_tx_reg, the valid/ready output holding register, reusable for future stream sources.

Test Plan:
Use DMEM_ADDR_WIDTH=2, RF_DEPTH=4; dmem={01,02,03,04}, rf={10,20,30,40}.
- Checksum build, tx_ready=1, pulse start: stream is A5 01 02 03 04 10 20 30 40 4F; done pulses once after 4F is accepted; busy is high throughout.
- Checksum undefined, same stimulus: stream is A5 01 02 03 04 10 20 30 40; done follows 40; no tenth byte.
- tx_ready=0 for 5 cycles while 02 is offered: tx_valid stays 1 and tx_data stays 02; stream completes unchanged after ready returns.
- start pulsed again while byte 03 is in flight: frame unchanged, single done, no second header.
- reset asserted during RF byte 20: outputs go to reset values asynchronously, no done; a new start yields a full correct frame from A5.
- Read-port check: dmem_rd_addr sequence 0,1,2,3, then rf_rd_addr 0..3; rd_en never asserted for both regions in the same cycle.

Source files
------------

// File: rtl/turtle_mem_dump_pkg.sv
// ============================================================================
// Module   : turtle_mem_dump_pkg
// Brief    : Shared turtle CPU dump types: FSM states, regions, frame header.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package turtle_mem_dump_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SEND_HDR  = 3'd1,
        RD_REQ    = 3'd2,
        RD_WAIT   = 3'd3,
        SEND_BYTE = 3'd4,
        SEND_SUM  = 3'd5,
        FINISH    = 3'd6
    } dump_state_t;

    typedef enum logic {
        REGION_DMEM = 1'b0,
        REGION_RF   = 1'b1
    } dump_region_t;

    localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

endpackage

`default_nettype wire

// File: rtl/turtle_mem_dump_tx_reg.sv
// ============================================================================
// Module   : turtle_mem_dump_tx_reg
// Brief    : Valid/ready output holding register; data is frozen until accepted.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turtle_mem_dump_tx_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_accept
);

    assign o_accept = o_valid & i_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_data  <= i_data;
            o_valid <= 1'b1;
        end else if (o_accept) begin
            o_valid <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: rtl/turtle_mem_dump.sv
// ============================================================================
// Module   : turtle_mem_dump
// Brief    : Streams header, data memory, register file (and optional checksum
//            when TURTLE_MEM_DUMP_CHECKSUM_EN is defined) as a byte frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module turtle_mem_dump
    import turtle_mem_dump_pkg::*;
#(
    parameter int         DMEM_ADDR_WIDTH = 8,
    parameter int         RF_DEPTH        = 16,
    parameter int         RF_ADDR_WIDTH   = $clog2(RF_DEPTH),
    parameter logic [7:0] HEADER_BYTE     = DUMP_HEADER_BYTE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    output logic                       dmem_rd_en,
    output logic [DMEM_ADDR_WIDTH-1:0] dmem_rd_addr,
    input  logic [7:0]                 dmem_rd_data,
    output logic                       rf_rd_en,
    output logic [RF_ADDR_WIDTH-1:0]   rf_rd_addr,
    input  logic [7:0]                 rf_rd_data,
    output logic [7:0]                 tx_data,
    output logic                       tx_valid,
    input  logic                       tx_ready,
    output logic                       busy,
    output logic                       done
);

    // Extra index bit lets "last entry" be detected as index+1 == size.
    localparam int IDX_W = ((DMEM_ADDR_WIDTH > RF_ADDR_WIDTH) ? DMEM_ADDR_WIDTH : RF_ADDR_WIDTH) + 1;
    localparam logic [IDX_W-1:0] C_DMEM_SIZE = IDX_W'(2**DMEM_ADDR_WIDTH);
    localparam logic [IDX_W-1:0] C_RF_SIZE   = IDX_W'(RF_DEPTH);

    dump_state_t      r_state;
    dump_region_t     r_region;
    logic [IDX_W-1:0] r_index;
`ifdef TURTLE_MEM_DUMP_CHECKSUM_EN
    logic [7:0]       r_checksum;
`endif

    logic [IDX_W-1:0] w_index_nxt;
    logic             w_region_end;
    logic             w_accept;
    logic             w_load;
    logic [7:0]       w_load_data;

    assign w_index_nxt  = r_index + 1'b1;
    assign w_region_end = (r_region == REGION_DMEM) ? (w_index_nxt == C_DMEM_SIZE)
                                                    : (w_index_nxt == C_RF_SIZE);

    always_comb begin
        w_load      = 1'b0;
        w_load_data = 8'h00;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_load_data = HEADER_BYTE;
                end
            end
            RD_WAIT: begin
                w_load      = 1'b1;
                w_load_data = (r_region == REGION_DMEM) ? dmem_rd_data : rf_rd_data;
            end
`ifdef TURTLE_MEM_DUMP_CHECKSUM_EN
            SEND_BYTE: begin
                // Checksum byte must include the RF byte being accepted right now.
                if (w_accept && w_region_end && (r_region == REGION_RF)) begin
                    w_load      = 1'b1;
                    w_load_data = r_checksum + tx_data;
                end
            end
`endif
            default: ;
        endcase
    end

    turtle_mem_dump_tx_reg #(
        .WIDTH (8)
    ) u_tx_reg (
        .clk      (clk),
        .rst      (reset),
        .i_load   (w_load),
        .i_data   (w_load_data),
        .i_ready  (tx_ready),
        .o_data   (tx_data),
        .o_valid  (tx_valid),
        .o_accept (w_accept)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_region     <= REGION_DMEM;
            r_index      <= '0;
            dmem_rd_en   <= 1'b0;
            dmem_rd_addr <= '0;
            rf_rd_en     <= 1'b0;
            rf_rd_addr   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            dmem_rd_en <= 1'b0;
            rf_rd_en   <= 1'b0;
            done       <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state  <= SEND_HDR;
                        busy     <= 1'b1;
                        r_index  <= '0;
                        r_region <= REGION_DMEM;
                    end
                end
                SEND_HDR: begin
                    if (w_accept) begin
                        r_state      <= RD_REQ;
                        dmem_rd_en   <= 1'b1;
                        dmem_rd_addr <= '0;
                    end
                end
                RD_REQ:  r_state <= RD_WAIT;
                RD_WAIT: r_state <= SEND_BYTE;
                SEND_BYTE: begin
                    if (w_accept) begin
                        if (!w_region_end) begin
                            r_state <= RD_REQ;
                            r_index <= w_index_nxt;
                            if (r_region == REGION_DMEM) begin
                                dmem_rd_en   <= 1'b1;
                                dmem_rd_addr <= w_index_nxt[DMEM_ADDR_WIDTH-1:0];
                            end else begin
                                rf_rd_en   <= 1'b1;
                                rf_rd_addr <= w_index_nxt[RF_ADDR_WIDTH-1:0];
                            end
                        end else if (r_region == REGION_DMEM) begin
                            r_state    <= RD_REQ;
                            r_region   <= REGION_RF;
                            r_index    <= '0;
                            rf_rd_en   <= 1'b1;
                            rf_rd_addr <= '0;
                        end else begin
`ifdef TURTLE_MEM_DUMP_CHECKSUM_EN
                            r_state <= SEND_SUM;
`else
                            r_state <= FINISH;
                            busy    <= 1'b0;
                            done    <= 1'b1;
`endif
                        end
                    end
                end
`ifdef TURTLE_MEM_DUMP_CHECKSUM_EN
                SEND_SUM: begin
                    if (w_accept) begin
                        r_state <= FINISH;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end
                end
`endif
                FINISH:  r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef TURTLE_MEM_DUMP_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_checksum <= 8'h00;
        end else if ((r_state == IDLE) && start) begin
            r_checksum <= 8'h00;
        end else if (w_accept) begin
            r_checksum <= r_checksum + tx_data;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_turtle_mem_dump.sv
// ============================================================================
// Module   : tb_turtle_mem_dump
// Brief    : Randomized self-checking bench for turtle_mem_dump against a
//            frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_turtle_mem_dump;

    localparam int DAW = 2;
    localparam int RFD = 4;
`ifdef TURTLE_MEM_DUMP_CHECKSUM_EN
    localparam int SUM_BYTES = 1;
`else
    localparam int SUM_BYTES = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       dmem_rd_en;
    logic [1:0] dmem_rd_addr;
    logic [7:0] dmem_rd_data = 8'h00;
    logic       rf_rd_en;
    logic [1:0] rf_rd_addr;
    logic [7:0] rf_rd_data = 8'h00;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       done;

    logic [7:0] dmem [4];
    logic [7:0] rf   [4];
    logic [7:0] got_q [$];
    int         dq [$];
    int         rq [$];
    int         n_checks = 0;
    int         n_errors = 0;

    turtle_mem_dump #(
        .DMEM_ADDR_WIDTH (DAW),
        .RF_DEPTH        (RFD)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .dmem_rd_en   (dmem_rd_en),
        .dmem_rd_addr (dmem_rd_addr),
        .dmem_rd_data (dmem_rd_data),
        .rf_rd_en     (rf_rd_en),
        .rf_rd_addr   (rf_rd_addr),
        .rf_rd_data   (rf_rd_data),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    // Synchronous-read memories: data appears the cycle after the strobe.
    always @(posedge clk) begin
        if (dmem_rd_en) dmem_rd_data <= dmem[dmem_rd_addr];
        if (rf_rd_en)   rf_rd_data   <= rf[rf_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string pfx);
        chk({pfx, "_tx_valid"}, {31'd0, tx_valid}, 0);
        chk({pfx, "_tx_data"},  {24'd0, tx_data}, 0);
        chk({pfx, "_busy"},     {31'd0, busy}, 0);
        chk({pfx, "_done"},     {31'd0, done}, 0);
        chk({pfx, "_rd_en"},    {30'd0, dmem_rd_en, rf_rd_en}, 0);
        chk({pfx, "_rd_addr"},  {28'd0, dmem_rd_addr, rf_rd_addr}, 0);
    endtask

    // mode 0: ready high, 1: random ready, 2: 5-cycle stall on byte 2
    task automatic run_frame(input int mode, input int restart_at, input int reset_at);
        logic [7:0] exp_q [$];
        logic [7:0] sum;
        logic [7:0] hold_data;
        int  done_cnt, done_cyc, viol, both, busy_bad, extra, stall_n, post, dn;
        bit  hold, restarted, aborted;

        got_q.delete(); dq.delete(); rq.delete();
        exp_q.push_back(8'hA5);
        sum = 8'hA5;
        for (int i = 0; i < 4; i++) begin exp_q.push_back(dmem[i]); sum += dmem[i]; end
        for (int i = 0; i < 4; i++) begin exp_q.push_back(rf[i]);   sum += rf[i];   end
        if (SUM_BYTES == 1) exp_q.push_back(sum);

        done_cnt = 0; done_cyc = -1; viol = 0; both = 0; busy_bad = 0; extra = 0;
        stall_n = 0; post = 0; hold = 0; restarted = 0; aborted = 0; hold_data = 8'h00;
        start    = 1'b1;
        tx_ready = 1'b1;

        for (int c = 0; c < 2000 && !(done_cnt > 0 && post >= 6) && !aborted; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (hold && (tx_valid !== 1'b1 || tx_data !== hold_data)) viol++;
            if (dmem_rd_en && rf_rd_en) both++;
            if (dmem_rd_en) dq.push_back(int'(dmem_rd_addr));
            if (rf_rd_en)   rq.push_back(int'(rf_rd_addr));
            if (done) begin
                done_cnt++;
                done_cyc = c;
                if (busy) busy_bad++;
            end else if (done_cnt == 0 && !busy) begin
                busy_bad++;
            end
            if (done_cnt > 0 && !done) begin
                post++;
                if (tx_valid || busy) extra++;
            end

            case (mode)
                1: tx_ready = ($urandom_range(0, 2) != 0);
                2: begin
                    if (tx_valid && got_q.size() == 2 && stall_n < 5) begin
                        tx_ready = 1'b0;
                        stall_n++;
                        if (tx_data !== exp_q[2]) viol++;
                    end else begin
                        tx_ready = 1'b1;
                    end
                end
                default: tx_ready = 1'b1;
            endcase

            if (restart_at >= 0 && !restarted && tx_valid && got_q.size() == restart_at) begin
                start     = 1'b1;
                restarted = 1'b1;
            end

            if (reset_at >= 0 && tx_valid && got_q.size() == reset_at) begin
                tx_ready = 1'b0;
                #2 reset = 1'b1;
                #1 check_idle_outputs("midrst");
                @(negedge clk);
                reset   = 1'b0;
                aborted = 1'b1;
            end

            hold      = tx_valid && !tx_ready;
            hold_data = tx_data;
            if (tx_valid && tx_ready && !aborted) got_q.push_back(tx_data);
        end

        if (aborted) begin
            dn = 0;
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                if (done || busy) dn++;
            end
            chk("midrst_quiet", dn, 0);
            return;
        end

        chk("done_pulses", done_cnt, 1);
        chk("frame_len", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            chk($sformatf("byte%0d", i), (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
        chk("hold_stable", viol, 0);
        chk("dual_rd_en", both, 0);
        chk("busy_shape", busy_bad, 0);
        chk("after_done", extra, 0);
        chk("dmem_reads", dq.size(), 4);
        chk("rf_reads", rq.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("dmem_addr%0d", i), (i < dq.size()) ? dq[i] : -1, i);
            chk($sformatf("rf_addr%0d", i),   (i < rq.size()) ? rq[i] : -1, i);
        end
        if (mode == 0) chk("done_cycle", done_cyc, 1 + 3 * 8 + SUM_BYTES);
        if (mode == 2) chk("stall_len", stall_n, 5);
    endtask

    task automatic load_fixed();
        for (int i = 0; i < 4; i++) begin
            dmem[i] = 8'(i + 1);
            rf[i]   = 8'((i + 1) * 16);
        end
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        tx_ready = 1'b0;
        load_fixed();
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk);

        run_frame(0, -1, -1);
        run_frame(2, -1, -1);
        run_frame(0, 3, -1);
        run_frame(0, -1, 6);
        run_frame(0, -1, -1);

        for (int f = 0; f < 6; f++) begin
            for (int i = 0; i < 4; i++) begin
                dmem[i] = 8'($urandom_range(0, 255));
                rf[i]   = 8'($urandom_range(0, 255));
            end
            run_frame((f % 2 == 0) ? 1 : 0, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
